mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single DRAM port between instruction fetch (IF) and the load/store stage (DM) of the RISCV core.
//  Sits between the core and the memory model and drives MemoryEnable/ReadNotWrite/address/write data.
//  Sequences each access over a fixed memory latency and returns data with a one-cycle valid pulse.
//  Stalls the losing requester until its access completes.
// PARAMETERS
//  ADDR_W     32  address width (the core's 64-bit addresses are truncated to [31:0] at top level)
//  DATA_W     32  data width
//  MEM_LAT    1   cycles from the MemoryEnable cycle to the cycle MemDout is valid; legal range 1..7
//  STARVE_MAX 4   consecutive DM grants allowed while if_req is pending before IF is forced
// PORTS
//  Clk          in   1       clock, rising edge
//  Rst          in   1       asynchronous reset, active-low
//  if_req       in   1       fetch request; held high with if_addr stable until if_valid
//  if_addr      in   ADDR_W  fetch address
//  if_rdata     out  DATA_W  fetch data, registered, valid while if_valid=1
//  if_valid     out  1       one-cycle completion pulse for IF
//  if_stall     out  1       if_req & ~if_valid (combinational)
//  dm_req       in   1       data request; held high with dm_* fields stable until dm_valid
//  dm_rnw       in   1       1=load, 0=store
//  dm_addr      in   ADDR_W  data address
//  dm_wdata     in   DATA_W  store data
//  dm_rdata     out  DATA_W  load data, registered; unchanged by stores
//  dm_valid     out  1       one-cycle completion pulse for DM (loads and stores)
//  dm_stall     out  1       dm_req & ~dm_valid (combinational)
//  MemoryEnable out  1       memory access strobe, one cycle per access
//  ReadNotWrite out  1       1=read, 0=write
//  MemAddr      out  ADDR_W  memory address
//  MemDin       out  DATA_W  memory write data
//  MemDout      in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (Rst=0, asynchronous): state=IDLE; all registered outputs 0; starvation counter 0.
//   Any in-flight access is abandoned with no valid pulse. MemoryEnable drops immediately.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: at the clock edge, if any request is pending, latch the winner (owner=IF/DM) and go to ISSUE.
//  ISSUE, 1 cycle: MemoryEnable=1 with registered MemAddr, ReadNotWrite and MemDin from the owner.
//   IF accesses always read; MemDin=0 for reads. Then go to WAIT and load cnt=MEM_LAT-1.
//  WAIT: cnt decrements each cycle. At the edge where cnt==0, capture MemDout into the owner's rdata
//   (loads and fetches only), then go to DONE.
//  DONE, 1 cycle: owner's valid=1. No arbitration in DONE; the requester updates its fields at this edge.
//  MemoryEnable, ReadNotWrite, MemAddr and MemDin are 0 outside ISSUE.
//  Latency: request seen in IDLE cycle N -> MemoryEnable in N+1 -> valid in N+MEM_LAT+2.
//   Minimum access spacing is MEM_LAT+3 cycles.
//  Arbitration:
//   - DM wins ties.
//   - starve_cnt increments on each DM grant while if_req=1. It clears on an IF grant or whenever if_req=0.
//   - If starve_cnt==STARVE_MAX and if_req=1, IF wins.
//   - starve_cnt saturates at STARVE_MAX.
//  Single requester: granted immediately. No request: remain in IDLE, all memory outputs 0.
//  A requester dropping req mid-access is a protocol violation. The access completes and the valid pulse is still issued.
//  rdata registers hold their value until the next completion for that owner.
// STRUCTURE
//  Shared include mem_arb_defs.vh holds:
//   - state encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE (2-bit);
//   - owner encodings OWN_IF=1'b0, OWN_DM=1'b1.
//  One sub-module: mem_lat_counter, a loadable 3-bit down-counter with a zero flag that times WAIT.
//  The FSM, arbitration and output registers live in mem_port_arbiter.
// TESTING
//  1. Reset mid-WAIT (Rst low for 1 cycle) -> MemoryEnable=0 immediately, no valid pulse, next request served normally.
//  2. MEM_LAT=1, IF only, addr 0x0000_0010, MemDout=0x0050_0093 -> MemoryEnable in N+1; if_valid in N+3 with if_rdata=0x0050_0093.
//  3. Simultaneous if_req and dm_req (load 0x0000_0100, MemDout=0xDEAD_BEEF) -> DM served first, dm_rdata=0xDEAD_BEEF.
//     IF is then issued; if_stall stays high until its if_valid.
//  4. Store dm_addr 0x0000_0200, dm_wdata 0x1234_5678 -> one cycle with MemoryEnable=1, ReadNotWrite=0,
//     MemDin=0x1234_5678; dm_valid pulses; dm_rdata unchanged.
//  5. dm_req held high across 6 accesses with if_req pending, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM.
//  6. MEM_LAT=3, back-to-back IF requests -> MemoryEnable pulses exactly 6 cycles apart, each if_valid a single cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the latency counter width.
package mem_port_arbiter_pkg;

  localparam int unsigned LatCntW = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the WAIT phase of an access.
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [LatCntW-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [LatCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LatCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE; DM wins ties unless IF has starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_rnw,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              MemoryEnable,
  output logic              ReadNotWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDin,
  input  logic [DATA_W-1:0] MemDout
);

  localparam int unsigned        StarveW   = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
  localparam logic [LatCntW-1:0] LatLoad   = LatCntW'(MEM_LAT - 1);

  arb_state_e         state_d, state_q;
  arb_owner_e         owner_d, owner_q;
  logic               op_rnw_d, op_rnw_q;
  logic [StarveW-1:0] starve_d, starve_q;

  logic               mem_en_d, mem_en_q;
  logic               mem_rnw_d, mem_rnw_q;
  logic [ADDR_W-1:0]  mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]  mem_din_d, mem_din_q;

  logic               if_valid_d, if_valid_q;
  logic               dm_valid_d, dm_valid_q;
  logic [DATA_W-1:0]  if_rdata_d, if_rdata_q;
  logic [DATA_W-1:0]  dm_rdata_d, dm_rdata_q;

  logic               grant_dm, grant_if;
  logic               cnt_load, cnt_dec, cnt_zero;

  mem_lat_counter u_lat_counter (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .load_i     (cnt_load),
    .load_val_i (LatLoad),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // A starved fetch overrides DM's tie-break priority.
  assign grant_dm = dm_req && !(if_req && (starve_q == StarveMax));
  assign grant_if = if_req && !grant_dm;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_rnw_d   = op_rnw_q;
    starve_d   = if_req ? starve_q : '0;
    mem_en_d   = 1'b0;
    mem_rnw_d  = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_dm) begin
          state_d    = StIssue;
          owner_d    = OwnDm;
          op_rnw_d   = dm_rnw;
          mem_en_d   = 1'b1;
          mem_rnw_d  = dm_rnw;
          mem_addr_d = dm_addr;
          mem_din_d  = dm_rnw ? '0 : dm_wdata;
          if (if_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
          end
        end else if (grant_if) begin
          state_d    = StIssue;
          owner_d    = OwnIf;
          op_rnw_d   = 1'b1;
          mem_en_d   = 1'b1;
          mem_rnw_d  = 1'b1;
          mem_addr_d = if_addr;
          starve_d   = '0;
        end
      end
      StIssue: begin
        state_d  = StWait;
        cnt_load = 1'b1;
      end
      StWait: begin
        if (cnt_zero) begin
          state_d = StDone;
          if (owner_q == OwnIf) begin
            if_valid_d = 1'b1;
            if_rdata_d = MemDout;
          end else begin
            dm_valid_d = 1'b1;
            if (op_rnw_q) begin
              dm_rdata_d = MemDout;
            end
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      op_rnw_q   <= 1'b0;
      starve_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_rnw_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_rnw_q   <= op_rnw_d;
      starve_q   <= starve_d;
      mem_en_q   <= mem_en_d;
      mem_rnw_q  <= mem_rnw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign MemoryEnable = mem_en_q;
  assign ReadNotWrite = mem_rnw_q;
  assign MemAddr      = mem_addr_q;
  assign MemDin       = mem_din_q;
  assign if_valid     = if_valid_q;
  assign dm_valid     = dm_valid_q;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;
  assign if_stall     = if_req & ~if_valid_q;
  assign dm_stall     = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// with a shared behavioural memory and per-requester scoreboards of expected read data.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Rst;

  logic        if_req, dm_req, dm_rnw;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, maddr, mdin, mdout;
  logic        if_valid, if_stall, dm_valid, dm_stall, me, rnw;

  logic        if3_req, dm3_req, dm3_rnw;
  logic [31:0] if3_addr, dm3_addr, dm3_wdata;
  logic [31:0] if3_rdata, dm3_rdata, maddr3, mdin3, mdout3;
  logic        if3_valid, if3_stall, dm3_valid, dm3_stall, me3, rnw3;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] if3_q[$];
  logic        grant_log[$];

  mem_port_arbiter #(.MEM_LAT(1)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_rnw(dm_rnw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .MemoryEnable(me), .ReadNotWrite(rnw), .MemAddr(maddr), .MemDin(mdin), .MemDout(mdout)
  );

  mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst),
    .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_valid(if3_valid),
    .if_stall(if3_stall),
    .dm_req(dm3_req), .dm_rnw(dm3_rnw), .dm_addr(dm3_addr), .dm_wdata(dm3_wdata),
    .dm_rdata(dm3_rdata), .dm_valid(dm3_valid), .dm_stall(dm3_stall),
    .MemoryEnable(me3), .ReadNotWrite(rnw3), .MemAddr(maddr3), .MemDin(mdin3),
    .MemDout(mdout3)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Read data appears from the edge after MemoryEnable and holds until the next read.
  always @(posedge Clk) begin
    if (me) begin
      if (rnw) mdout <= mem_rd(maddr);
      else mem[maddr] = mdin;
    end
    if (me3 && rnw3) mdout3 <= mem_rd(maddr3);
  end

  always @(negedge Clk) begin
    if (if_valid) begin
      check1("if_q_avail", if_q.size() != 0, 1'b1);
      if (if_q.size() != 0) check32("if_rdata", if_rdata, if_q.pop_front());
      grant_log.push_back(1'b0);
    end
    if (dm_valid) begin
      check1("dm_q_avail", dm_q.size() != 0, 1'b1);
      if (dm_q.size() != 0) check32("dm_rdata", dm_rdata, dm_q.pop_front());
      grant_log.push_back(1'b1);
    end
    if (if3_valid) begin
      check1("if3_q_avail", if3_q.size() != 0, 1'b1);
      if (if3_q.size() != 0) check32("if3_rdata", if3_rdata, if3_q.pop_front());
    end
  end

  initial begin
    int   w;
    int   n_done;
    int   cyc, n_v, n_me, first_v;
    int   me_cyc[3];
    logic prev_v;
    logic exp_order[6];

    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    Rst = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_rnw = 0; dm_addr = 0; dm_wdata = 0;
    if3_req = 0; if3_addr = 0; dm3_req = 0; dm3_rnw = 0; dm3_addr = 0; dm3_wdata = 0;
    mdout = 0; mdout3 = 0;
    mem[32'h10]  = 32'h0050_0093;
    mem[32'h20]  = 32'h1111_1111;
    mem[32'h30]  = 32'hAAAA_0030;
    mem[32'h40]  = 32'h0BAD_F00D;
    mem[32'h50]  = 32'h5050_5050;
    mem[32'h58]  = 32'h5858_5858;
    mem[32'h60]  = 32'h6060_0001;
    mem[32'h64]  = 32'h6464_0002;
    mem[32'h68]  = 32'h6868_0003;
    mem[32'h100] = 32'hDEAD_BEEF;

    repeat (2) @(negedge Clk);
    check1("rst_me", me, 1'b0);
    check1("rst_me3", me3, 1'b0);
    check1("rst_valid", if_valid | dm_valid, 1'b0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_dm_rdata", dm_rdata, 32'h0);
    check32("rst_maddr", maddr, 32'h0);
    Rst = 1'b1;
    @(negedge Clk);

    // Reset while one access is in WAIT and another is in ISSUE.
    if3_req = 1; if3_addr = 32'h58;
    @(negedge Clk);
    check1("t1_u3_issue", me3, 1'b1);
    if_req = 1; if_addr = 32'h50;
    @(negedge Clk);
    check1("t1_u1_issue", me, 1'b1);
    Rst = 1'b0;
    #1;
    check1("t1_me_drop", me, 1'b0);
    check1("t1_me3_drop", me3, 1'b0);
    if_req = 0; if3_req = 0;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check1("t1_no_valid", if_valid | if3_valid, 1'b0);
    end

    // IF alone at MEM_LAT=1.
    if_req = 1; if_addr = 32'h10; if_q.push_back(32'h0050_0093);
    @(negedge Clk);
    check1("t2_me", me, 1'b1);
    check1("t2_rnw", rnw, 1'b1);
    check32("t2_maddr", maddr, 32'h10);
    check32("t2_mdin", mdin, 32'h0);
    check1("t2_stall", if_stall, 1'b1);
    @(negedge Clk);
    check1("t2_me_off", me, 1'b0);
    check32("t2_maddr_off", maddr, 32'h0);
    check1("t2_not_yet", if_valid, 1'b0);
    @(negedge Clk);
    check1("t2_valid_n3", if_valid, 1'b1);
    check1("t2_stall_off", if_stall, 1'b0);
    if_req = 0;
    @(negedge Clk);
    check1("t2_single", if_valid, 1'b0);

    // Simultaneous requests: DM first, IF stalls until served.
    dm_req = 1; dm_rnw = 1; dm_addr = 32'h100; dm_q.push_back(32'hDEAD_BEEF);
    if_req = 1; if_addr = 32'h20; if_q.push_back(32'h1111_1111);
    @(negedge Clk);
    check1("t3_me", me, 1'b1);
    check32("t3_dm_first", maddr, 32'h100);
    check1("t3_dm_stall", dm_stall, 1'b1);
    w = 0;
    while (!dm_valid && w < 8) begin
      @(negedge Clk);
      w++;
    end
    check1("t3_dm_done", dm_valid, 1'b1);
    check1("t3_if_pending", if_valid, 1'b0);
    dm_req = 0;
    w = 0;
    do begin
      @(negedge Clk);
      w++;
      if (!if_valid) check1("t3_if_stall", if_stall, 1'b1);
    end while (!if_valid && w < 10);
    check1("t3_if_done", if_valid, 1'b1);
    if_req = 0;
    @(negedge Clk);

    // Store, then read the same address back.
    dm_req = 1; dm_rnw = 0; dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
    dm_q.push_back(32'hDEAD_BEEF);
    @(negedge Clk);
    check1("t4_me", me, 1'b1);
    check1("t4_write", rnw, 1'b0);
    check32("t4_maddr", maddr, 32'h200);
    check32("t4_mdin", mdin, 32'h1234_5678);
    @(negedge Clk);
    check32("t4_mdin_off", mdin, 32'h0);
    @(negedge Clk);
    check1("t4_valid", dm_valid, 1'b1);
    dm_rnw = 1; dm_q.push_back(32'h1234_5678);
    w = 0;
    do begin
      @(negedge Clk);
      w++;
    end while (!dm_valid && w < 8);
    check1("t4_readback_done", dm_valid, 1'b1);
    dm_req = 0;
    @(negedge Clk);

    // DM held high with IF pending: IF forced after STARVE_MAX DM grants.
    grant_log.delete();
    dm_req = 1; dm_rnw = 1; dm_addr = 32'h40;
    if_req = 1; if_addr = 32'h30;
    repeat (5) dm_q.push_back(32'h0BAD_F00D);
    if_q.push_back(32'hAAAA_0030);
    n_done = 0; w = 0;
    while (n_done < 6 && w < 80) begin
      @(negedge Clk);
      w++;
      if (if_valid) begin
        if_req = 0;
        n_done++;
      end
      if (dm_valid) begin
        n_done++;
        if (n_done == 6) dm_req = 0;
      end
    end
    dm_req = 0; if_req = 0;
    check32("t5_done", 32'(n_done), 32'd6);
    repeat (2) @(negedge Clk);
    check32("t5_log_len", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check1($sformatf("t5_grant%0d", i), grant_log[i], exp_order[i]);
    end

    // Back-to-back IF at MEM_LAT=3.
    if3_req = 1; if3_addr = 32'h60;
    if3_q.push_back(32'h6060_0001);
    if3_q.push_back(32'h6464_0002);
    if3_q.push_back(32'h6868_0003);
    cyc = 0; n_v = 0; n_me = 0; first_v = 0; prev_v = 1'b0;
    me_cyc = '{0, 0, 0};
    while (n_v < 3 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (prev_v) check1("t6_single_pulse", if3_valid, 1'b0);
      if (me3) begin
        if (n_me < 3) me_cyc[n_me] = cyc;
        n_me++;
      end
      if (if3_valid) begin
        if (n_v == 0) first_v = cyc;
        n_v++;
        if3_addr = if3_addr + 32'd4;
        if (n_v == 3) if3_req = 0;
      end else begin
        check1("t6_stall", if3_stall, 1'b1);
      end
      prev_v = if3_valid;
    end
    @(negedge Clk);
    check1("t6_last_single", if3_valid, 1'b0);
    check32("t6_valids", 32'(n_v), 32'd3);
    check32("t6_me_count", 32'(n_me), 32'd3);
    check32("t6_first_me", 32'(me_cyc[0]), 32'd1);
    check32("t6_first_valid", 32'(first_v), 32'd5);
    check32("t6_gap01", 32'(me_cyc[1] - me_cyc[0]), 32'd6);
    check32("t6_gap12", 32'(me_cyc[2] - me_cyc[1]), 32'd6);

    repeat (3) @(negedge Clk);
    check32("end_if_q", 32'(if_q.size()), 32'd0);
    check32("end_dm_q", 32'(dm_q.size()), 32'd0);
    check32("end_if3_q", 32'(if3_q.size()), 32'd0);
    check1("end_u3_dm_idle", dm3_valid | dm3_stall, 1'b0);
    check32("end_u3_dm_rdata", dm3_rdata, 32'h0);
    check32("end_u3_mdin", mdin3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
